// File: rtl/hazard_pkg.sv
// Shared types for the hazard/stall controller:
// FSM states, output classes and their control decode.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    CLS_FREEZE = 2'd0,
    CLS_FLOW   = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_LU     = 2'd3
  } cls_t;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic idExWrite;
    logic exMemWrite;
    logic memWbWrite;
    logic ifIdFlush;
    logic idExFlush;
  } ctrl_t;

  function automatic ctrl_t clsCtrl(cls_t cls);
    ctrl_t c;
    c = '0;
    case (cls)
      CLS_FLOW:   c = 7'b1111100;
      CLS_BRANCH: c = 7'b1111111;
      CLS_LU:     c = 7'b0011101;
      default:    c = 7'b0000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-unit bundle: pipeline status in,
// register enables, flushes and counters out.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);

  logic [REG_ADDR_W-1:0] if_id_rs;
  logic [REG_ADDR_W-1:0] if_id_rt;
  logic                  id_uses_rt;
  logic                  id_ex_memRead;
  logic [REG_ADDR_W-1:0] id_ex_rt;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  PCWrite;
  logic                  IF_ID_write;
  logic                  ID_EX_write;
  logic                  EX_MEM_write;
  logic                  MEM_WB_write;
  logic                  IF_ID_flush;
  logic                  ID_EX_flush;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output if_id_rs, if_id_rt, id_uses_rt,
    output id_ex_memRead, id_ex_rt,
    output ex_branch_taken, mem_req, mem_ready,
    input  PCWrite, IF_ID_write, ID_EX_write,
    input  EX_MEM_write, MEM_WB_write,
    input  IF_ID_flush, ID_EX_flush,
    input  stall_count, flush_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, id_uses_rt,
    input  id_ex_memRead, id_ex_rt,
    input  ex_branch_taken, mem_req, mem_ready,
    output PCWrite, IF_ID_write, ID_EX_write,
    output EX_MEM_write, MEM_WB_write,
    output IF_ID_flush, ID_EX_flush,
    output stall_count, flush_count
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones,
// never wraps back to zero.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up on inc until all-ones
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use, branch-flush and memory-wait sequencing
// for the 5-stage pipeline, plus event counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input logic                Clk,
  input logic                Reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam int REM_W =
    (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;

  state_t           state;
  state_t           stateNext;
  state_t           ret;
  state_t           retNext;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] remNext;
  cls_t             cls;
  ctrl_t            ctrl;
  logic             hz;
  logic             memWait;
  logic             runRule;
  logic             luRule;
  logic             stallInc;
  logic             flushInc;

  assign hz = bus.id_ex_memRead
    && (bus.id_ex_rt != REG_ADDR_W'(REG_ZERO))
    && ((bus.id_ex_rt == bus.if_id_rs)
      || (bus.id_uses_rt
        && (bus.id_ex_rt == bus.if_id_rt)));

  assign memWait = bus.mem_req && !bus.mem_ready;

  // a released MEM_WAIT re-runs its return state's rules
  assign runRule =
    ((state == RUN) && !memWait)
    || ((state == MEM_WAIT) && bus.mem_ready
      && (ret == RUN));

  assign luRule =
    ((state == LU_STALL) && !memWait)
    || ((state == MEM_WAIT) && bus.mem_ready
      && (ret == LU_STALL));

  // state, return state and remaining-stall register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= RUN;
      ret   <= RUN;
      rem   <= '0;
    end else begin
      state <= stateNext;
      ret   <= retNext;
      rem   <= remNext;
    end
  end

  // next-state selection
  always_comb begin
    stateNext = state;
    retNext   = ret;
    remNext   = rem;
    unique case (1'b1)
      runRule: begin
        stateNext = RUN;
        if (!bus.ex_branch_taken && hz
            && (LOAD_STALL_CYCLES > 1)) begin
          stateNext = LU_STALL;
          remNext   = REM_W'(LOAD_STALL_CYCLES - 1);
        end
      end
      luRule: begin
        remNext   = rem - 1'b1;
        stateNext = (rem == REM_W'(1)) ? RUN : LU_STALL;
      end
      default: begin
        stateNext = MEM_WAIT;
        if (state != MEM_WAIT) begin
          retNext = (state == LU_STALL) ? LU_STALL : RUN;
        end
      end
    endcase
  end

  // output class for this cycle
  always_comb begin
    cls = CLS_FREEZE;
    unique case (1'b1)
      runRule: begin
        if (bus.ex_branch_taken) begin
          cls = CLS_BRANCH;
        end else if (hz) begin
          cls = CLS_LU;
        end else begin
          cls = CLS_FLOW;
        end
      end
      luRule:  cls = CLS_LU;
      default: cls = CLS_FREEZE;
    endcase
  end

  assign ctrl = Reset ? clsCtrl(cls) : '0;

  assign bus.PCWrite      = ctrl.pcWrite;
  assign bus.IF_ID_write  = ctrl.ifIdWrite;
  assign bus.ID_EX_write  = ctrl.idExWrite;
  assign bus.EX_MEM_write = ctrl.exMemWrite;
  assign bus.MEM_WB_write = ctrl.memWbWrite;
  assign bus.IF_ID_flush  = ctrl.ifIdFlush;
  assign bus.ID_EX_flush  = ctrl.idExFlush;

  assign stallInc = (cls == CLS_LU) || (cls == CLS_FREEZE);
  assign flushInc = (cls == CLS_BRANCH);

  sat_counter #(.W(CNT_W)) stallCnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (stallInc),
    .count (bus.stall_count)
  );

  sat_counter #(.W(CNT_W)) flushCnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (flushInc),
    .count (bus.flush_count)
  );

endmodule
